pixel_unpacker: RTL



---
 rtl/pixel_unpacker_pkg.sv | 42 ++++
 rtl/pixel_unpacker.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pixel_unpacker_pkg.sv
// Shared constants and types for the packed-RGB video stream: frame geometry
// defaults, coordinate widths, byte-lane offsets and RGB field positions.
package pixel_unpacker_pkg;

  localparam int X_SIZE_DEF = 640;
  localparam int Y_SIZE_DEF = 480;
  localparam int X_W        = 10;
  localparam int Y_W        = 9;

  localparam int PIX_W      = 24;
  localparam int WORD_W     = 32;

  // Byte-lane offsets within a 32-bit stream word
  localparam int LANE1_LSB  = 8;
  localparam int LANE2_LSB  = 16;
  localparam int LANE3_LSB  = 24;

  // RGB field positions within a 24-bit pixel (b in the LSB)
  localparam int R_LSB      = 16;
  localparam int G_LSB      = 8;
  localparam int B_LSB      = 0;

  typedef enum logic {
    ST_WAIT_SOF = 1'b0,
    ST_RUN      = 1'b1
  } state_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  function automatic rgb_t to_rgb(input logic [PIX_W-1:0] p);
    rgb_t c;
    c.r = p[R_LSB +: 8];
    c.g = p[G_LSB +: 8];
    c.b = p[B_LSB +: 8];
    return c;
  endfunction

endpackage

// File: rtl/pixel_unpacker.sv
// Unpacks 4 pixels from every 3 stream words into a one-deep pixel output
// register with x/y coordinates, frame sync on tuser and tlast framing checks.
module pixel_unpacker
  import pixel_unpacker_pkg::*;
#(
  parameter int X_SIZE = X_SIZE_DEF,
  parameter int Y_SIZE = Y_SIZE_DEF
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [WORD_W-1:0] in_stream_tdata,
  input  logic [3:0]        in_stream_tkeep,
  input  logic              in_stream_tlast,
  input  logic              in_stream_tuser,
  input  logic              in_stream_tvalid,
  output logic              in_stream_tready,
  output logic [7:0]        r,
  output logic [7:0]        g,
  output logic [7:0]        b,
  output logic [X_W-1:0]    x,
  output logic [Y_W-1:0]    y,
  output logic              pix_sof,
  output logic              pix_eol,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              err_sof,
  output logic              err_tlast
);

  localparam logic [X_W-1:0] X_LAST = X_W'(X_SIZE - 1);
  localparam logic [X_W-1:0] X_PEN  = X_W'(X_SIZE - 2);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(Y_SIZE - 1);

  state_e            state_q, state_d;
  logic [1:0]        phase_q, phase_d;
  logic [PIX_W-1:0]  res_q, res_d;
  logic [X_W-1:0]    nx_q, nx_d;
  logic [Y_W-1:0]    ny_q, ny_d;
  rgb_t              pix_q, pix_d;
  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic              sof_q, sof_d;
  logic              eol_q, eol_d;
  logic              pix_valid_q, pix_valid_d;
  logic              err_sof_q, err_sof_d;
  logic              err_tlast_q, err_tlast_d;

  logic              load_en;
  logic              word_rdy;
  logic              word_acc;
  logic              restart;
  logic              new_pix;
  logic              tlast_exp;
  logic [PIX_W-1:0]  new_rgb;
  logic [X_W-1:0]    cur_x;
  logic [Y_W-1:0]    cur_y;

  // tkeep carries no information in this format
  logic unused_tkeep;
  assign unused_tkeep = ^in_stream_tkeep;

  always_comb begin
    // NOTE: every comb output gets a default before any branch so no path can leave it unassigned (no latch).
    state_d     = state_q;
    phase_d     = phase_q;
    res_d       = res_q;
    nx_d        = nx_q;
    ny_d        = ny_q;
    pix_d       = pix_q;
    x_d         = x_q;
    y_d         = y_q;
    sof_d       = sof_q;
    eol_d       = eol_q;
    pix_valid_d = pix_valid_q;
    err_sof_d   = 1'b0;
    err_tlast_d = 1'b0;
    load_en     = !pix_valid_q || pix_ready;
    word_rdy    = 1'b0;
    word_acc    = 1'b0;
    restart     = 1'b0;
    new_pix     = 1'b0;
    tlast_exp   = 1'b0;
    new_rgb     = '0;

    case (state_q)
      ST_WAIT_SOF: begin
        word_rdy = 1'b1;
        if (in_stream_tvalid && in_stream_tuser) begin
          word_acc = 1'b1;
          restart  = 1'b1;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        word_rdy = load_en && (phase_q != 2'd3);
        if (phase_q == 2'd3) begin
          // Fourth pixel of the group comes entirely from the residual
          if (load_en) begin
            new_pix = 1'b1;
            new_rgb = res_q;
            phase_d = 2'd0;
          end
        end else if (in_stream_tvalid && word_rdy) begin
          word_acc = 1'b1;
          if (in_stream_tuser && !(phase_q == 2'd0 && nx_q == '0 && ny_q == '0)) begin
            err_sof_d = 1'b1;
            restart   = 1'b1;
          end else begin
            new_pix   = 1'b1;
            phase_d   = phase_q + 2'd1;
            tlast_exp = (phase_q == 2'd2) && (nx_q == X_PEN);
            case (phase_q)
              2'd0: begin
                new_rgb = in_stream_tdata[PIX_W-1:0];
                res_d   = {16'h0, in_stream_tdata[LANE3_LSB +: 8]};
              end
              2'd1: begin
                new_rgb = {in_stream_tdata[15:0], res_q[7:0]};
                res_d   = {8'h0, in_stream_tdata[LANE2_LSB +: 16]};
              end
              default: begin
                new_rgb = {in_stream_tdata[7:0], res_q[15:0]};
                res_d   = in_stream_tdata[LANE1_LSB +: 24];
              end
            endcase
          end
        end
      end
      default: state_d = ST_WAIT_SOF;
    endcase

    // A frame-start word is always w0 of pixel (0,0); any residual is discarded
    if (restart) begin
      new_pix = 1'b1;
      new_rgb = in_stream_tdata[PIX_W-1:0];
      res_d   = {16'h0, in_stream_tdata[LANE3_LSB +: 8]};
      phase_d = 2'd1;
    end

    cur_x = restart ? '0 : nx_q;
    cur_y = restart ? '0 : ny_q;

    if (word_acc) err_tlast_d = (in_stream_tlast != tlast_exp);

    if (new_pix) begin
      pix_d       = to_rgb(new_rgb);
      x_d         = cur_x;
      y_d         = cur_y;
      sof_d       = (cur_x == '0) && (cur_y == '0);
      eol_d       = (cur_x == X_LAST);
      pix_valid_d = 1'b1;
      if (cur_x == X_LAST) begin
        nx_d = '0;
        ny_d = (cur_y == Y_LAST) ? '0 : cur_y + Y_W'(1);
      end else begin
        nx_d = cur_x + X_W'(1);
        ny_d = cur_y;
      end
    end else if (load_en) begin
      pix_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together from pre-edge values.
  // NOTE: the pixel datapath is reset too, so outputs read as zero rather than X before the first frame.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= ST_WAIT_SOF;
      phase_q     <= 2'd0;
      res_q       <= '0;
      nx_q        <= '0;
      ny_q        <= '0;
      pix_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      sof_q       <= 1'b0;
      eol_q       <= 1'b0;
      pix_valid_q <= 1'b0;
      err_sof_q   <= 1'b0;
      err_tlast_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      res_q       <= res_d;
      nx_q        <= nx_d;
      ny_q        <= ny_d;
      pix_q       <= pix_d;
      x_q         <= x_d;
      y_q         <= y_d;
      sof_q       <= sof_d;
      eol_q       <= eol_d;
      pix_valid_q <= pix_valid_d;
      err_sof_q   <= err_sof_d;
      err_tlast_q <= err_tlast_d;
    end
  end

  assign in_stream_tready = word_rdy;
  assign r         = pix_q.r;
  assign g         = pix_q.g;
  assign b         = pix_q.b;
  assign x         = x_q;
  assign y         = y_q;
  assign pix_sof   = sof_q;
  assign pix_eol   = eol_q;
  assign pix_valid = pix_valid_q;
  assign err_sof   = err_sof_q;
  assign err_tlast = err_tlast_q;

endmodule
